// File: rtl/cmd_strobe_rx.sv
// Command strobe front end: synchronises and glitch-filters I_CLK/I_C, forwards
// normal commands and turns the 7,0,7,0,n unlock sequence into a discharge request.
module cmd_strobe_rx #(
  parameter int FILT_CYCLES = 8,
  parameter int SEQ_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       I_CLK,
  input  logic [2:0] I_C,
  output logic       cmd_valid,
  output logic [2:0] cmd_code,
  output logic       disch_valid,
  output logic [2:0] disch_sel,
  output logic       seq_abort,
  output logic       armed,
  output logic       strobe_err
);

  localparam int FW = $clog2(FILT_CYCLES + 1);
  localparam int TW = $clog2(SEQ_TIMEOUT + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(SEQ_TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, S7A, S0A, S7B, ARMED} state_t;

  logic          strb_s1, strb_s2;
  logic [2:0]    code_s1, code_s2;
  logic          filt_lvl, filt_prev;
  logic [FW-1:0] filt_cnt;
  logic [2:0]    cap_code;
  logic          err_seen;
  logic [TW-1:0] tmo_cnt;
  state_t        state;
  logic          accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      strb_s1 <= 1'b0;
      strb_s2 <= 1'b0;
      code_s1 <= 3'd0;
      code_s2 <= 3'd0;
    end else begin
      strb_s1 <= I_CLK;
      strb_s2 <= strb_s1;
      code_s1 <= I_C;
      code_s2 <= code_s1;
    end
  end

  // Level only flips after FILT_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_lvl  <= 1'b0;
      filt_prev <= 1'b0;
      filt_cnt  <= '0;
    end else begin
      filt_prev <= filt_lvl;
      if (strb_s2 == filt_lvl) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_LAST) begin
        filt_lvl <= ~filt_lvl;
        filt_cnt <= '0;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

  assign accept = filt_lvl & ~filt_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_code   <= 3'd0;
      err_seen   <= 1'b0;
      strobe_err <= 1'b0;
    end else begin
      strobe_err <= 1'b0;
      if (accept) begin
        cap_code <= code_s2;
        err_seen <= 1'b0;
      end else if (filt_lvl && !err_seen && (code_s2 != cap_code)) begin
        strobe_err <= 1'b1;
        err_seen   <= 1'b1;
      end
    end
  end

  // An accept in the timeout cycle takes priority, so no abort is raised then.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      cmd_valid   <= 1'b0;
      cmd_code    <= 3'd0;
      disch_valid <= 1'b0;
      disch_sel   <= 3'd0;
      seq_abort   <= 1'b0;
      armed       <= 1'b0;
    end else begin
      cmd_valid   <= 1'b0;
      disch_valid <= 1'b0;
      seq_abort   <= 1'b0;
      armed       <= (state == ARMED);
      if (accept) begin
        tmo_cnt <= '0;
        case (code_s2)
          3'd7: state <= (state == S0A) ? S7B : S7A;
          3'd0: begin
            cmd_valid <= 1'b1;
            cmd_code  <= 3'd0;
            case (state)
              S7A:     state <= S0A;
              S7B:     state <= ARMED;
              default: state <= IDLE;
            endcase
          end
          3'd1, 3'd2, 3'd3, 3'd4: begin
            if (state == ARMED) begin
              disch_valid <= 1'b1;
              disch_sel   <= code_s2;
            end else begin
              cmd_valid <= 1'b1;
              cmd_code  <= code_s2;
            end
            state <= IDLE;
          end
          default: begin
            cmd_valid <= 1'b1;
            cmd_code  <= code_s2;
            state     <= IDLE;
          end
        endcase
      end else if (state == IDLE) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt == TMO_LAST) begin
        state     <= IDLE;
        seq_abort <= 1'b1;
        tmo_cnt   <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cmd_strobe_rx.sv
// Randomised scoreboard bench for cmd_strobe_rx: an event-level model predicts
// command/discharge/abort pulses, a monitor pops and compares them.
module tb_cmd_strobe_rx;

  localparam int FILT  = 8;
  localparam int SEQ_T = 400;
  localparam int EW    = 37;
  localparam int LAT   = FILT + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       I_CLK = 1'b0;
  logic [2:0] I_C = 3'd0;
  logic       cmd_valid, disch_valid, seq_abort, armed, strobe_err;
  logic [2:0] cmd_code, disch_sel;

  cmd_strobe_rx #(.FILT_CYCLES(FILT), .SEQ_TIMEOUT(SEQ_T)) dut (
    .clk(clk), .rst(rst), .I_CLK(I_CLK), .I_C(I_C),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .disch_valid(disch_valid), .disch_sel(disch_sel),
    .seq_abort(seq_abort), .armed(armed), .strobe_err(strobe_err)
  );

  // clock / reset block
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard state: entries are {kind, value, expected cycle}
  logic [EW-1:0] exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  int err_exp = 0;
  int err_seen = 0;
  int p = 0;          // how much of the unlock pattern 7,0,7,0 has been matched
  int last_rise = 0;
  int pat[4] = '{7, 0, 7, 0};
  logic [2:0] held_code = 3'd0;
  logic [2:0] held_sel = 3'd0;

  function automatic logic [EW-1:0] mk(logic [1:0] k, logic [2:0] v, int t);
    return {k, v, 32'(t)};
  endfunction

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_accept(logic [2:0] c, int rise);
    bit to_disch;
    to_disch = (p == 4) && (c >= 3'd1) && (c <= 3'd4);
    if (to_disch) exp_q.push_back(mk(2'd1, c, rise + LAT));
    else if (c != 3'd7) exp_q.push_back(mk(2'd0, c, rise + LAT));
    if (p < 4 && int'(c) == pat[p]) p = p + 1;
    else if (c == 3'd7) p = 1;
    else p = 0;
    last_rise = rise;
  endtask

  task automatic check_armed(string name);
    vectors++;
    if (armed !== (p == 4)) begin
      miscompares++;
      $display("FAIL %s: armed=%0b expected %0b", name, armed, (p == 4));
    end
  endtask

  task automatic check_quiet(string name);
    vectors++;
    if ({cmd_valid, cmd_code, disch_valid, disch_sel, seq_abort, armed, strobe_err} !== 11'd0) begin
      miscompares++;
      $display("FAIL %s: outputs=%b expected all zero", name,
               {cmd_valid, cmd_code, disch_valid, disch_sel, seq_abort, armed, strobe_err});
    end
  endtask

  task automatic long_gap();
    if (p != 0) begin
      exp_q.push_back(mk(2'd2, 3'd0, last_rise + LAT + SEQ_T));
      p = 0;
      tick(SEQ_T + 40);
    end
  endtask

  // driver: err_at < 0 means I_C stays stable for the whole high phase
  task automatic strobe(logic [2:0] c, int high, int err_at);
    int rise;
    if (p != 0 && (cyc - last_rise) > SEQ_T / 2) long_gap();
    I_C = c;
    tick(1);
    rise = cyc;
    I_CLK = 1'b1;
    if (high >= FILT) model_accept(c, rise);
    for (int i = 0; i < high; i++) begin
      if (i == err_at) begin
        I_C = c ^ 3'd3;
        if (high >= FILT) err_exp++;
      end
      tick(1);
    end
    I_CLK = 1'b0;
    tick(FILT + 6);
    check_armed("armed_after_strobe");
  endtask

  // monitor
  always @(negedge clk) begin
    if (!rst) begin
      if (strobe_err) err_seen++;
      if (cmd_valid && disch_valid) begin
        vectors++;
        miscompares++;
        $display("FAIL both_valid at cycle %0d", cyc);
      end
      if (cmd_valid || disch_valid || seq_abort) begin
        logic [1:0] k;
        logic [2:0] v;
        k = cmd_valid ? 2'd0 : (disch_valid ? 2'd1 : 2'd2);
        v = cmd_valid ? cmd_code : (disch_valid ? disch_sel : 3'd0);
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_pulse: kind=%0d val=%0d at cycle %0d, none expected", k, v, cyc);
        end else begin
          logic [EW-1:0] e;
          int t;
          e = exp_q.pop_front();
          t = int'(e[31:0]);
          if (k !== e[36:35] || v !== e[34:32] || cyc < t - 1 || cyc > t + 1) begin
            miscompares++;
            $display("FAIL pulse: got kind=%0d val=%0d cycle=%0d, expected kind=%0d val=%0d cycle=%0d",
                     k, v, cyc, e[36:35], e[34:32], t);
          end
          if (e[36:35] == 2'd0) held_code = e[34:32];
          if (e[36:35] == 2'd1) held_sel = e[34:32];
        end
      end
      vectors++;
      if (cmd_code !== held_code || disch_sel !== held_sel) begin
        miscompares++;
        $display("FAIL hold: cmd_code=%0d disch_sel=%0d expected %0d/%0d at cycle %0d",
                 cmd_code, disch_sel, held_code, held_sel, cyc);
      end
    end
  end

  initial begin
    int rise;
    logic [2:0] c;
    int high, err_at;
    tick(5);
    check_quiet("reset_state");
    rst = 1'b0;

    // basic command, glitches and filter-length boundary
    strobe(3'd1, 50, -1);
    strobe(3'd5, 5, -1);
    strobe(3'd6, FILT - 1, -1);
    strobe(3'd6, FILT, -1);

    // unlock sequences ending in discharge selectors 3 and 1
    strobe(3'd7, 20, -1); strobe(3'd0, 20, -1); strobe(3'd7, 20, -1); strobe(3'd0, 20, -1);
    strobe(3'd3, 20, -1);
    strobe(3'd7, 20, -1); strobe(3'd0, 20, -1); strobe(3'd7, 20, -1); strobe(3'd0, 20, -1);
    strobe(3'd1, 20, -1);

    // timeout, then a normal command
    strobe(3'd7, 20, -1); strobe(3'd0, 20, -1);
    long_gap();
    strobe(3'd2, 20, -1);

    // start command breaks the unlock
    strobe(3'd7, 20, -1); strobe(3'd0, 20, -1); strobe(3'd7, 20, -1); strobe(3'd5, 20, -1);
    strobe(3'd0, 20, -1); strobe(3'd1, 20, -1);

    // code change while strobe high
    strobe(3'd1, 30, FILT + 8);

    // reset while armed and mid-strobe; held strobe is accepted once afterwards
    strobe(3'd7, 20, -1); strobe(3'd0, 20, -1); strobe(3'd7, 20, -1); strobe(3'd0, 20, -1);
    I_C = 3'd3;
    tick(1);
    I_CLK = 1'b1;
    tick(5);
    rst = 1'b1;
    tick(3);
    check_quiet("mid_strobe_reset");
    held_code = 3'd0;
    held_sel = 3'd0;
    p = 0;
    rst = 1'b0;
    rise = cyc;
    model_accept(3'd3, rise);
    tick(30);
    I_CLK = 1'b0;
    tick(FILT + 6);
    check_armed("armed_after_reset");

    // randomised traffic
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 99) < 45) c = (p < 4) ? 3'(pat[p]) : 3'($urandom_range(1, 4));
      else c = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 99) < 15) high = $urandom_range(1, FILT - 1);
      else high = $urandom_range(FILT, 30);
      err_at = -1;
      if (high >= FILT + 10 && $urandom_range(0, 99) < 15) err_at = FILT + 5 + $urandom_range(0, 3);
      strobe(c, high, err_at);
      if ($urandom_range(0, 99) < 8) long_gap();
    end
    long_gap();

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expected pulses never seen, required 0", exp_q.size());
    end
    vectors++;
    if (err_seen != err_exp) begin
      miscompares++;
      $display("FAIL strobe_err_count: got %0d expected %0d", err_seen, err_exp);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
